// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_pkg
//  Description : Shared constants and width helpers for the sigma-delta CIC
//                decimator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdm_pkg;

    localparam int AUDIO_W   = 16;
    localparam int CIC_ORDER = 3;

    // Register growth of an order-N CIC is N*log2(R) bits on top of the
    // 1-bit-plus-sign input.
    function automatic int cic_width(input int decim);
        return CIC_ORDER * $clog2(decim) + 1;
    endfunction

    function automatic bit decim_ok(input int decim);
        return (decim >= 32) && (decim <= 256) && ((decim & (decim - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : cic_integrator
//  Description : WIDTH-bit wrapping accumulator with enable; exposes the
//                post-add value so stages can be chained within one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_integrator #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_sum;

    assign w_sum = r_acc + i_din;
    assign o_sum = w_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdm_cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : sdm_cic_decimator
//  Description : 3rd-order CIC decimator turning a 1-bit sigma-delta stream
//                into 16-bit signed PCM, one sample per DECIM accepted bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdm_cic_decimator
    import sdm_pkg::*;
#(
    parameter int DECIM = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic                      sdm_in,
    output logic                      valid_out,
    output logic signed [AUDIO_W-1:0] audio_out
);

    localparam int c_w     = cic_width(DECIM);
    localparam int c_log   = $clog2(DECIM);
    localparam int c_shift = c_w - AUDIO_W;

    localparam logic [c_log-1:0]     c_last_count = c_log'(DECIM - 1);
    localparam logic [c_w-1:0]       c_plus_one   = c_w'(1);
    localparam logic [c_w-1:0]       c_min_code   = {1'b1, {(c_w-1){1'b0}}};
    localparam logic signed [c_w:0]  c_sat_hi     = (c_w+1)'(2**(AUDIO_W-1) - 1);
    localparam logic signed [c_w:0]  c_sat_lo     = ~c_sat_hi;

    generate
        if (!decim_ok(DECIM)) begin : g_bad_decim
            $fatal(1, "sdm_cic_decimator: DECIM must be a power of two in 32..256");
        end
    endgenerate

    logic [c_log-1:0] r_count;
    logic             w_frame_done;
    logic [c_w-1:0]   w_step;
    logic [c_w-1:0]   w_sum1;
    logic [c_w-1:0]   w_sum2;
    logic [c_w-1:0]   w_sum3;

    assign w_frame_done = valid_in && (r_count == c_last_count);
    assign w_step       = sdm_in ? c_plus_one : {c_w{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (valid_in) begin
            r_count <= r_count + 1'b1;
        end
    end

    cic_integrator #(.WIDTH(c_w)) u_integ1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (valid_in),
        .i_din (w_step),
        .o_sum (w_sum1)
    );

    cic_integrator #(.WIDTH(c_w)) u_integ2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (valid_in),
        .i_din (w_sum1),
        .o_sum (w_sum2)
    );

    cic_integrator #(.WIDTH(c_w)) u_integ3 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (valid_in),
        .i_din (w_sum2),
        .o_sum (w_sum3)
    );

    // Frame snapshot: integrator-3 total including the closing bit.
    logic           r_strobe;
    logic [c_w-1:0] r_snap;
    logic           r_frame_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_strobe    <= 1'b0;
            r_snap      <= '0;
            r_frame_bit <= 1'b0;
        end else begin
            r_strobe <= w_frame_done;
            if (w_frame_done) begin
                r_snap      <= w_sum3;
                r_frame_bit <= sdm_in;
            end
        end
    end

    logic [c_w-1:0] r_d1;
    logic [c_w-1:0] r_d2;
    logic [c_w-1:0] r_d3;
    logic [c_w-1:0] w_c1;
    logic [c_w-1:0] w_c2;
    logic [c_w-1:0] w_c3;

    assign w_c1 = r_snap - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_c3 = w_c2 - r_d3;

    // Full-scale +1 input wraps onto the same code as full-scale -1. That code
    // is only reachable when every bit in the filter window is identical, so
    // the frame's closing bit tells which extreme it really is.
    logic signed [c_w:0] w_ext;
    logic signed [c_w:0] w_shifted;
    logic [AUDIO_W-1:0]  w_sat;

    always_comb begin
        w_ext = '0;
        if ((w_c3 == c_min_code) && r_frame_bit) begin
            w_ext = {1'b0, w_c3};
        end else begin
            w_ext = {w_c3[c_w-1], w_c3};
        end
    end

    assign w_shifted = w_ext >>> c_shift;

    always_comb begin
        w_sat = '0;
        if (w_shifted > c_sat_hi) begin
            w_sat = c_sat_hi[AUDIO_W-1:0];
        end else if (w_shifted < c_sat_lo) begin
            w_sat = c_sat_lo[AUDIO_W-1:0];
        end else begin
            w_sat = w_shifted[AUDIO_W-1:0];
        end
    end

    logic                      r_valid;
    logic signed [AUDIO_W-1:0] r_audio;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d1    <= '0;
            r_d2    <= '0;
            r_d3    <= '0;
            r_valid <= 1'b0;
            r_audio <= '0;
        end else begin
            r_valid <= r_strobe;
            if (r_strobe) begin
                r_d1    <= r_snap;
                r_d2    <= w_c1;
                r_d3    <= w_c2;
                r_audio <= w_sat;
            end
        end
    end

    assign valid_out = r_valid;
    assign audio_out = r_audio;

endmodule
`default_nettype wire

// File: tb/tb_sdm_cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdm_cic_decimator
//  Description : Directed self-checking bench for sdm_cic_decimator, DECIM=64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdm_cic_decimator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_in;
    logic               sdm_in;
    logic               valid_out;
    logic signed [15:0] audio_out;

    always #5 clk = ~clk;

    sdm_cic_decimator #(.DECIM(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sdm_in    (sdm_in),
        .valid_out (valid_out),
        .audio_out (audio_out)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   base   = 0;
    int   consec = 0;
    logic prev_v = 1'b0;
    logic nz_before = 1'b0;
    int   q_vals[$];
    int   q_cyc[$];

    // One clock: drive, clock, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic b);
        valid_in = v;
        sdm_in   = b;
        @(posedge clk);
        cyc++;
        #1;
        if (valid_out) begin
            if (prev_v) consec++;
            q_vals.push_back(int'(audio_out));
            q_cyc.push_back(cyc - base);
        end else if (q_vals.size() == 0 && audio_out != 16'sd0) begin
            nz_before = 1'b1;
        end
        prev_v = valid_out;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int val(input int i);
        return (i < q_vals.size()) ? q_vals[i] : -99999;
    endfunction

    function automatic int pcyc(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -99999;
    endfunction

    task automatic clear_capture();
        q_vals.delete();
        q_cyc.delete();
        base      = cyc;
        nz_before = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        clear_capture();
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sdm_in   = 1'b0;

        // Reset state
        do_reset();
        check("reset_audio", int'(audio_out), 0);
        check("reset_valid", int'(valid_out), 0);

        // All ones, continuous: C(66,3)/8, (C(130,3)-3*C(66,3))/8, then saturated
        repeat (6*64 + 2) step(1'b1, 1'b1);
        check("ones_count", q_vals.size(), 6);
        check("ones_latency", pcyc(0), 65);
        check("ones_s1", val(0), 5720);
        check("ones_s2", val(1), 27560);
        for (int i = 2; i < 6; i++) check($sformatf("ones_s%0d", i + 1), val(i), 32767);
        for (int i = 0; i < 5; i++) check($sformatf("ones_gap%0d", i), pcyc(i + 1) - pcyc(i), 64);

        // All zeros
        do_reset();
        repeat (5*64 + 2) step(1'b1, 1'b0);
        check("zeros_count", q_vals.size(), 5);
        check("zeros_s1", val(0), -5720);
        check("zeros_s2", val(1), -27560);
        check("zeros_s4", val(3), -32768);
        check("zeros_s5", val(4), -32768);

        // Alternating 1,0
        do_reset();
        for (int i = 0; i < 5*64 + 2; i++) step(1'b1, (i % 2) == 0);
        check("alt_count", q_vals.size(), 5);
        check("alt_s4", val(3), 0);
        check("alt_s5", val(4), 0);

        // All ones with valid_in toggling; sdm_in driven low in the gaps
        do_reset();
        for (int i = 0; i < 5*128 + 2; i++) step((i % 2) == 0, (i % 2) == 0);
        check("gap_count", q_vals.size(), 5);
        check("gap_latency", pcyc(0), 128);
        check("gap_s1", val(0), 5720);
        check("gap_s2", val(1), 27560);
        check("gap_s4", val(3), 32767);
        check("gap_s5", val(4), 32767);
        for (int i = 0; i < 4; i++) check($sformatf("gap_spacing%0d", i), pcyc(i + 1) - pcyc(i), 128);

        // Reset 20 bits into frame 3
        do_reset();
        repeat (128 + 20) step(1'b1, 1'b1);
        check("midrst_pre_count", q_vals.size(), 2);
        rst_n = 1'b0;
        step(1'b1, 1'b1);
        check("midrst_audio", int'(audio_out), 0);
        check("midrst_valid", int'(valid_out), 0);
        rst_n = 1'b1;
        clear_capture();
        repeat (70) step(1'b1, 1'b1);
        check("midrst_count", q_vals.size(), 1);
        check("midrst_latency", pcyc(0), 65);
        check("midrst_s1", val(0), 5720);
        check("midrst_held_zero", int'(nz_before), 0);

        // Reset landing in the cycle between frame completion and output
        do_reset();
        repeat (64) step(1'b1, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 1'b1);
        check("t1rst_valid", int'(valid_out), 0);
        check("t1rst_audio", int'(audio_out), 0);
        rst_n = 1'b1;
        clear_capture();
        repeat (10) step(1'b0, 1'b0);
        check("t1rst_no_pulse", q_vals.size(), 0);
        check("t1rst_audio_hold", int'(audio_out), 0);

        check("no_back_to_back", consec, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
